// File: rtl/tgt_ddr_rx.sv
// DDR target receiver: deserialises SDA on SCL edge strobes into preamble/byte/parity/CRC fields (optional CRC checking under TGT_DDR_RX_CRC_CHECK_EN).
// Latency: results and done appear one cycle after the last bit is sampled; no backpressure, bits are taken whenever strobed.
module tgt_ddr_rx (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_sclgen_scl_pos_edge,
  input  logic       i_sclgen_scl_neg_edge,
  input  logic       i_sdahnd_tgt_serial_data,
  input  logic       i_ddrccc_rx_en,
  input  logic [2:0] i_ddrccc_rx_mode,
  input  logic [4:0] i_crc_crc_value,
  output logic       o_ddrccc_rx_mode_done,
  output logic       o_ddrccc_preamble,
  output logic [7:0] o_regf_rx_parallel_data,
  output logic       o_regf_wr_en,
  output logic       o_crc_en,
  output logic [7:0] o_crc_parallel_data,
  output logic       o_ddrccc_parity_err,
  output logic       o_ddrccc_crc_err
);
  localparam logic [2:0] MODE_PRE  = 3'b000;
  localparam logic [2:0] MODE_BYTE = 3'b001;
  localparam logic [2:0] MODE_PAR  = 3'b011;
  localparam logic [2:0] MODE_TOK  = 3'b010;
  localparam logic [2:0] MODE_VAL  = 3'b110;

  logic [2:0]  cnt_q;
  logic [2:0]  mode_q;
  logic [6:0]  shift_q;
  logic [15:0] word_q;
  logic        toggle_q;
  logic [3:0]  field_len;
  logic        strobe, active, sample, restart, last_bit;
  logic [2:0]  bit_idx;
  logic [7:0]  rx_bits;
  logic [1:0]  parity_exp;

  always_comb begin
    field_len = 4'd0;
    case (i_ddrccc_rx_mode)
      MODE_PRE:  field_len = 4'd1;
      MODE_BYTE: field_len = 4'd8;
      MODE_PAR:  field_len = 4'd2;
      MODE_TOK:  field_len = 4'd4;
      MODE_VAL:  field_len = 4'd5;
      default:   field_len = 4'd0;
    endcase
  end

  assign strobe   = i_sclgen_scl_pos_edge | i_sclgen_scl_neg_edge;
  assign active   = i_ddrccc_rx_en && (field_len != 4'd0);
  assign sample   = active && strobe;
  // A mode change mid-field drops the partial bits; a coincident strobe becomes bit 0 of the new field.
  assign restart  = (i_ddrccc_rx_mode != mode_q) && (cnt_q != 3'd0);
  assign bit_idx  = restart ? 3'd0 : cnt_q;
  assign last_bit = sample && ({1'b0, bit_idx} == field_len - 4'd1);
  assign rx_bits  = {shift_q, i_sdahnd_tgt_serial_data};
  assign parity_exp = {^(word_q & 16'hAAAA), ~^(word_q & 16'h5555)};

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      cnt_q                   <= 3'd0;
      mode_q                  <= 3'd0;
      shift_q                 <= 7'd0;
      word_q                  <= 16'd0;
      toggle_q                <= 1'b0;
      o_ddrccc_rx_mode_done   <= 1'b0;
      o_ddrccc_preamble       <= 1'b0;
      o_regf_rx_parallel_data <= 8'd0;
      o_regf_wr_en            <= 1'b0;
      o_crc_en                <= 1'b0;
      o_crc_parallel_data     <= 8'd0;
      o_ddrccc_parity_err     <= 1'b0;
    end else begin
      mode_q                <= i_ddrccc_rx_mode;
      o_ddrccc_rx_mode_done <= 1'b0;
      o_regf_wr_en          <= 1'b0;
      o_crc_en              <= 1'b0;
      if (!active) begin
        cnt_q    <= 3'd0;
        toggle_q <= 1'b0;
      end else if (sample) begin
        shift_q <= rx_bits[6:0];
        if (last_bit) begin
          cnt_q                 <= 3'd0;
          o_ddrccc_rx_mode_done <= 1'b1;
          case (i_ddrccc_rx_mode)
            MODE_PRE: o_ddrccc_preamble <= i_sdahnd_tgt_serial_data;
            MODE_BYTE: begin
              o_regf_rx_parallel_data <= rx_bits;
              o_crc_parallel_data     <= rx_bits;
              o_regf_wr_en            <= 1'b1;
              o_crc_en                <= 1'b1;
              toggle_q                <= ~toggle_q;
              if (toggle_q) word_q[7:0]  <= rx_bits;
              else          word_q[15:8] <= rx_bits;
            end
            MODE_PAR: o_ddrccc_parity_err <= (rx_bits[1:0] != parity_exp);
            default: ;
          endcase
        end else begin
          cnt_q <= bit_idx + 3'd1;
        end
      end else if (restart) begin
        cnt_q <= 3'd0;
      end
    end
  end

`ifdef TGT_DDR_RX_CRC_CHECK_EN
  // Error is cleared by the first bit of a token so a token+value pair reports only its own result.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      o_ddrccc_crc_err <= 1'b0;
    end else if (sample) begin
      if (i_ddrccc_rx_mode == MODE_TOK) begin
        if (bit_idx == 3'd0)
          o_ddrccc_crc_err <= 1'b0;
        else if (last_bit && (rx_bits[3:0] != 4'b1100))
          o_ddrccc_crc_err <= 1'b1;
      end else if ((i_ddrccc_rx_mode == MODE_VAL) && last_bit && (rx_bits[4:0] != i_crc_crc_value)) begin
        o_ddrccc_crc_err <= 1'b1;
      end
    end
  end
`else
  logic unused_crc_value;
  assign unused_crc_value = ^i_crc_crc_value;
  assign o_ddrccc_crc_err = 1'b0;
`endif
endmodule

// File: tb/tb_tgt_ddr_rx.sv
// Bench for tgt_ddr_rx: directed scenarios then random fields against a field-level reference model.
module tb_tgt_ddr_rx;
  localparam logic [2:0] M_PRE = 3'b000, M_BYTE = 3'b001, M_PAR = 3'b011, M_TOK = 3'b010, M_VAL = 3'b110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pos = 1'b0, neg = 1'b0, sda = 1'b0, rx_en = 1'b0;
  logic [2:0] rx_mode = 3'b111;
  logic [4:0] crc_in = 5'd0;
  logic       done, pre, wr_en, crc_en, par_err, crc_err;
  logic [7:0] data, crc_data;

  int checks = 0;
  int errors = 0;

  logic        m_pre = 1'b0, m_par = 1'b0, m_crc = 1'b0, m_hi = 1'b1;
  logic [7:0]  m_data = 8'd0;
  logic [15:0] m_word = 16'd0;

  tgt_ddr_rx dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_sclgen_scl_pos_edge(pos), .i_sclgen_scl_neg_edge(neg),
    .i_sdahnd_tgt_serial_data(sda),
    .i_ddrccc_rx_en(rx_en), .i_ddrccc_rx_mode(rx_mode),
    .i_crc_crc_value(crc_in),
    .o_ddrccc_rx_mode_done(done), .o_ddrccc_preamble(pre),
    .o_regf_rx_parallel_data(data), .o_regf_wr_en(wr_en),
    .o_crc_en(crc_en), .o_crc_parallel_data(crc_data),
    .o_ddrccc_parity_err(par_err), .o_ddrccc_crc_err(crc_err)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input logic d, input logic w);
    chk("done", {15'd0, done}, {15'd0, d});
    chk("wr_en", {15'd0, wr_en}, {15'd0, w});
    chk("crc_en", {15'd0, crc_en}, {15'd0, w});
    chk("data", {8'd0, data}, {8'd0, m_data});
    chk("crc_data", {8'd0, crc_data}, {8'd0, m_data});
    chk("preamble", {15'd0, pre}, {15'd0, m_pre});
    chk("parity_err", {15'd0, par_err}, {15'd0, m_par});
    chk("crc_err", {15'd0, crc_err}, {15'd0, m_crc});
  endtask

  function automatic int flen(input logic [2:0] mode);
    case (mode)
      M_PRE: return 1;
      M_BYTE: return 8;
      M_PAR: return 2;
      M_TOK: return 4;
      M_VAL: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pre = 0; m_par = 0; m_crc = 0; m_hi = 1; m_data = 0; m_word = 0;
  endtask

  // Expected effect of one complete field, straight from the field rules.
  task automatic model_field(input logic [2:0] mode, input logic [7:0] val);
    logic p1, p0;
    case (mode)
      M_PRE: m_pre = val[0];
      M_BYTE: begin
        m_data = val;
        if (m_hi) m_word[15:8] = val; else m_word[7:0] = val;
        m_hi = !m_hi;
      end
      M_PAR: begin
        p1 = ($countones(m_word & 16'hAAAA) % 2) == 1;
        p0 = ($countones(m_word & 16'h5555) % 2) == 0;
        m_par = (val[1:0] != {p1, p0});
      end
`ifdef TGT_DDR_RX_CRC_CHECK_EN
      M_TOK: m_crc = (val[3:0] != 4'b1100);
      M_VAL: if (val[4:0] != crc_in) m_crc = 1'b1;
`endif
      default: ;
    endcase
  endtask

  // Send the first k bits (MSB first) of an n-bit value; done must stay low until the final bit.
  task automatic send_bits(input logic [2:0] mode, input logic [7:0] val, input int n, input int k);
    int r;
    rx_mode = mode;
    rx_en = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      r = $urandom_range(1, 3);
      sda = val[n-1-i];
      pos = r[0];
      neg = r[1];
      @(negedge clk);
      pos = 0; neg = 0;
      if (i != n-1) begin
        chk("no_early_done", {15'd0, done}, 16'd0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  task automatic do_field(input logic [2:0] mode, input logic [7:0] val, input logic [4:0] crcv);
    crc_in = crcv;
    send_bits(mode, val, flen(mode), flen(mode));
    model_field(mode, val);
    chk_all(1'b1, mode == M_BYTE);
    @(negedge clk);
    chk_all(1'b0, 1'b0);
  endtask

  initial begin
    int sel;
    logic [7:0] v;
    logic [4:0] c;

    #1 rst = 1'b0;
    #2 chk_all(1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);

    do_field(M_PRE, 8'h01, 5'd0);
    do_field(M_BYTE, 8'hA5, 5'd0);
    do_field(M_BYTE, 8'h3C, 5'd0);
    do_field(M_PAR, 8'h01, 5'd0);
    chk("parity_ok", {15'd0, par_err}, 16'd0);
    do_field(M_BYTE, 8'hA5, 5'd0);
    do_field(M_BYTE, 8'h3C, 5'd0);
    do_field(M_PAR, 8'h03, 5'd0);
    chk("parity_bad", {15'd0, par_err}, 16'd1);

    do_field(M_TOK, 8'h0C, 5'b10110);
    do_field(M_VAL, 8'h16, 5'b10110);
    chk("crc_match", {15'd0, crc_err}, 16'd0);
    do_field(M_TOK, 8'h0C, 5'b10110);
    do_field(M_VAL, 8'h17, 5'b10110);
`ifdef TGT_DDR_RX_CRC_CHECK_EN
    chk("crc_mismatch", {15'd0, crc_err}, 16'd1);
`else
    chk("crc_mismatch", {15'd0, crc_err}, 16'd0);
`endif

    // Asynchronous reset in the middle of a byte.
    send_bits(M_BYTE, 8'hF0, 8, 3);
    #2 rst = 1'b0;
    model_reset();
    #1 chk_all(1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) chk_all(1'b0, 1'b0);
    do_field(M_BYTE, 8'h3C, 5'd0);

    // Mode switch mid-byte discards the partial field.
    send_bits(M_BYTE, 8'hFF, 8, 4);
    rx_mode = M_PRE;
    @(negedge clk) chk_all(1'b0, 1'b0);
    @(negedge clk) chk_all(1'b0, 1'b0);
    do_field(M_PRE, 8'h00, 5'd0);

    // rx_en dropped mid-byte: outputs hold, byte position restarts at the high half.
    send_bits(M_BYTE, 8'h5A, 8, 5);
    rx_en = 1'b0;
    m_hi = 1'b1;
    repeat (2) @(negedge clk) chk_all(1'b0, 1'b0);

    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 6);
      v = 8'($urandom);
      c = 5'($urandom);
      case (sel)
        0: do_field(M_PRE, v, c);
        1, 2: do_field(M_BYTE, v, c);
        3: do_field(M_PAR, v, c);
        4: begin
          if ($urandom_range(0, 1) == 1) v[3:0] = 4'b1100;
          do_field(M_TOK, v, c);
        end
        5: begin
          if ($urandom_range(0, 1) == 1) v[4:0] = c;
          do_field(M_VAL, v, c);
        end
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            rx_en = 1'b0;
          end else begin
            rx_mode = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b111;
          end
          m_hi = 1'b1;
          for (int j = 0; j < 3; j++) begin
            @(negedge clk) pos = 1'b1; sda = v[j];
            @(negedge clk) pos = 1'b0;
            chk_all(1'b0, 1'b0);
          end
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tgt_ddr_rx.md
TGT_DDR_RX -- requirements
Module: tgt_ddr_rx

Interface
REQ-001 SHALL have port: i_sys_clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: i_sys_rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: i_sclgen_scl_pos_edge, i_sclgen_scl_neg_edge  input  1 each  one-cycle SCL edge strobes; "bit strobe" = OR of the two.
REQ-004 SHALL have port: i_sdahnd_tgt_serial_data  input  1  SDA as seen by target.
REQ-005 SHALL have ports: i_ddrccc_rx_en  input  1  enable; i_ddrccc_rx_mode  input  3  field select.
REQ-006 SHALL have port: i_crc_crc_value  input  5  running CRC5 from CRC block.
REQ-007 SHALL have ports: o_ddrccc_rx_mode_done  output  1  field-complete pulse; o_ddrccc_preamble  output  1  last preamble bit.
REQ-008 SHALL have ports: o_regf_rx_parallel_data  output  8  received byte; o_regf_wr_en  output  1  byte-valid pulse.
REQ-009 SHALL have ports: o_crc_en  output  1; o_crc_parallel_data  output  8  byte handed to CRC block.
REQ-010 SHALL have ports: o_ddrccc_parity_err, o_ddrccc_crc_err  output  1 each  sticky error flags.

Function
REQ-011 Modes SHALL be: 000 PREAMBLE (1 bit), 001 DESER_BYTE (8 bits), 011 PARITY_CHECK (2 bits), 010 CRC_TOKEN (4 bits), 110 CRC_VALUE (5 bits); other codes = IDLE.
REQ-012 SDA SHALL be sampled only in cycles with rx_en=1 and bit strobe=1; bits arrive MSB first; a 3-bit counter tracks position.
REQ-013 On the cycle the last bit of a field is sampled, counter SHALL return to 0 and o_ddrccc_rx_mode_done SHALL be 1 on the following cycle, for exactly one cycle.
REQ-014 PREAMBLE: sampled bit SHALL be registered into o_ddrccc_preamble together with done.
REQ-015 DESER_BYTE: on done, o_regf_rx_parallel_data and o_crc_parallel_data SHALL carry the byte, o_regf_wr_en and o_crc_en SHALL pulse one cycle, aligned with done.
REQ-016 A byte toggle SHALL store the 1st byte of a word in word[15:8], the 2nd in word[7:0], then toggle back.
REQ-017 PARITY_CHECK: expected P1 = XOR of word odd bits 15..1; P0 = XOR of even bits 14..0 XOR 1; received bits = {P1,P0}; mismatch SHALL set o_ddrccc_parity_err, match SHALL clear it, updated with done.
REQ-018 CRC_TOKEN: received 4 bits SHALL be compared to 4'b1100; mismatch SHALL set o_ddrccc_crc_err with done.
REQ-019 CRC_VALUE: received 5 bits SHALL be compared to i_crc_crc_value sampled at the last bit; mismatch SHALL set o_ddrccc_crc_err.
REQ-020 o_ddrccc_crc_err SHALL clear only on reset or when a CRC_TOKEN field starts with rx_en=1.
REQ-021 A mode change while counter != 0 SHALL discard the partial field: counter = 0, no done, no write.
REQ-022 rx_en=0 SHALL clear counter and byte toggle and force done, wr_en, crc_en to 0; data and error outputs SHALL hold.
REQ-023 IDLE mode SHALL behave as rx_en=0.

Reset
REQ-024 On i_sys_rst=0, all outputs, counter, byte toggle, word and shift registers SHALL go to 0 immediately, regardless of clock.
REQ-025 Reset mid-field SHALL abort the field with no done pulse after release; the first strobe after release starts at bit 0.

Configuration
REQ-026 Macro TGT_DDR_RX_CRC_CHECK_EN defined: REQ-018..020 active.
REQ-027 Macro TGT_DDR_RX_CRC_CHECK_EN undefined: CRC_TOKEN/CRC_VALUE SHALL still consume bits and pulse done, o_ddrccc_crc_err SHALL be tied 0, and i_crc_crc_value SHALL be ignored.

Verification
REQ-028 DESER_BYTE, SDA 1,0,1,0,0,1,0,1 on 8 strobes -> one cycle later done=1, wr_en=1, crc_en=1, data=0xA5.
REQ-029 Bytes 0xA5, 0x3C then PARITY_CHECK with bits 0,1 -> parity_err=0; repeat with bits 1,1 -> parity_err=1.
REQ-030 CRC_TOKEN bits 1,1,0,0 then CRC_VALUE 5'b10110 with i_crc_crc_value=5'b10110 -> crc_err=0; value 5'b10111 -> crc_err=1 (macro defined), crc_err=0 (undefined).
REQ-031 PREAMBLE, SDA=1 at one strobe -> next cycle preamble=1, done=1 for one cycle.
REQ-032 Async reset asserted after 3 bits of DESER_BYTE -> outputs 0 at once; after release, 8 fresh bits 0x3C -> data=0x3C with a single done.
REQ-033 Mode switched DESER_BYTE->PREAMBLE after 4 bits -> no wr_en; next strobe yields PREAMBLE done.
